// File: rtl/uc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// state enum, datapath mux/ALU codes and the decoded opcode/funct values.
package uc_pkg;

  typedef enum logic [4:0] {
    ST_FETCH    = 5'd0,
    ST_DECODE   = 5'd1,
    ST_RTYPE_EX = 5'd2,
    ST_RTYPE_WB = 5'd3,
    ST_ADDI_EX  = 5'd4,
    ST_ADDI_WB  = 5'd5,
    ST_BEQ      = 5'd6,
    ST_BNE      = 5'd7,
    ST_MEM_ADDR = 5'd8,
    ST_LW_RD    = 5'd9,
    ST_LW_WB    = 5'd10,
    ST_SW_WR    = 5'd11,
    ST_LUI      = 5'd12,
    ST_J        = 5'd13,
    ST_JAL      = 5'd14,
    ST_JR       = 5'd15,
    ST_BREAK    = 5'd16,
    ST_EXC      = 5'd17
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_PASS  = 3'b011;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_BREAK = 6'h0D;

  localparam logic CAUSE_OPCODE   = 1'b0;
  localparam logic CAUSE_OVERFLOW = 1'b1;

  // States that stretch over MEM_WAIT+1 cycles using the wait counter
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_LW_RD) || (s == ST_SW_WR);
  endfunction

endpackage

// File: rtl/uc_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath with parametrised memory wait states.
// Optional exception path (EXC state, EPC/Cause) is enabled by defining UC_EXCEPTION_EN.
module uc_multicycle_ctrl
  import uc_pkg::*;
#(
  parameter int unsigned MEM_WAIT    = 2,
  parameter logic [1:0]  EXC_VEC_SEL = 2'b11
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Overflow,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       AWrite,
  output logic       BWrite,
  output logic       MDRWrite,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       BranchNe,
  output logic       EPCWrite,
  output logic       Cause,
  output logic       Break,
  output logic [4:0] State
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state_r, state_next_s;
  logic [3:0] cnt_r, cnt_next_s;
  logic       cause_r, cause_next_s;
  logic       wait_done_s;
  logic       wb_write_s;

  assign wait_done_s = (cnt_r == WAIT_LAST);

`ifdef UC_EXCEPTION_EN
  assign wb_write_s = ~Overflow;
`else
  logic exc_unused;
  assign wb_write_s = 1'b1;
  assign exc_unused = ^{Overflow, EXC_VEC_SEL};
`endif

  // State, wait counter and latched exception cause
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_FETCH;
      cnt_r   <= 4'd0;
      cause_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      cause_r <= cause_next_s;
    end
  end

  // Next-state dispatch; the counter only advances while a wait state is held
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = 4'd0;
    cause_next_s = cause_r;
    case (state_r)
      ST_FETCH, ST_LW_RD, ST_SW_WR: begin
        if (!wait_done_s) begin
          cnt_next_s = cnt_r + 4'd1;
        end else if (state_r == ST_FETCH) begin
          state_next_s = ST_DECODE;
        end else if (state_r == ST_LW_RD) begin
          state_next_s = ST_LW_WB;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (Op)
          OP_RTYPE: begin
            if (Funct == FN_BREAK) begin
              state_next_s = ST_BREAK;
            end else if (Funct == FN_JR) begin
              state_next_s = ST_JR;
            end else begin
              state_next_s = ST_RTYPE_EX;
            end
          end
          OP_BEQ:        state_next_s = ST_BEQ;
          OP_BNE:        state_next_s = ST_BNE;
          OP_ADDI:       state_next_s = ST_ADDI_EX;
          OP_LW, OP_SW:  state_next_s = ST_MEM_ADDR;
          OP_LUI:        state_next_s = ST_LUI;
          OP_J:          state_next_s = ST_J;
          OP_JAL:        state_next_s = ST_JAL;
          default: begin
`ifdef UC_EXCEPTION_EN
            state_next_s = ST_EXC;
            cause_next_s = CAUSE_OPCODE;
`else
            state_next_s = ST_FETCH;
`endif
          end
        endcase
      end
      ST_RTYPE_EX: state_next_s = ST_RTYPE_WB;
      ST_ADDI_EX:  state_next_s = ST_ADDI_WB;
      ST_LUI:      state_next_s = ST_ADDI_WB;
      ST_MEM_ADDR: state_next_s = (Op == OP_SW) ? ST_SW_WR : ST_LW_RD;
      ST_RTYPE_WB, ST_ADDI_WB: begin
`ifdef UC_EXCEPTION_EN
        if (Overflow) begin
          state_next_s = ST_EXC;
          cause_next_s = CAUSE_OVERFLOW;
        end else begin
          state_next_s = ST_FETCH;
        end
`else
        state_next_s = ST_FETCH;
`endif
      end
      ST_BREAK: state_next_s = ST_BREAK;
      default:  state_next_s = ST_FETCH;
    endcase
  end

  // Moore outputs decoded from state; everything is held at zero during Reset
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    AWrite      = 1'b0;
    BWrite      = 1'b0;
    MDRWrite    = 1'b0;
    PCSource    = PCS_ALU;
    ALUOp       = ALU_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    RegDst      = DST_RT;
    MemtoReg    = M2R_ALUOUT;
    BranchNe    = 1'b0;
    EPCWrite    = 1'b0;
    Cause       = 1'b0;
    Break       = 1'b0;
    State       = 5'd0;
    if (Reset) begin
      State = 5'd0;
    end else begin
      State = state_r;
      Cause = cause_r;
      case (state_r)
        ST_FETCH: begin
          ALUSrcB = SRCB_FOUR;
          IRWrite = wait_done_s;
          PCWrite = wait_done_s;
        end
        ST_DECODE: begin
          AWrite  = 1'b1;
          BWrite  = 1'b1;
          ALUSrcB = SRCB_IMM_SH;
        end
        ST_RTYPE_EX: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALU_FUNCT;
        end
        ST_RTYPE_WB: begin
          RegWrite = wb_write_s;
          RegDst   = DST_RD;
        end
        ST_ADDI_EX, ST_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        ST_ADDI_WB: RegWrite = wb_write_s;
        ST_BEQ, ST_BNE: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCS_ALUOUT;
          BranchNe    = (state_r == ST_BNE);
        end
        ST_LW_RD: begin
          IorD     = 1'b1;
          MDRWrite = wait_done_s;
        end
        ST_LW_WB: begin
          RegWrite = 1'b1;
          MemtoReg = M2R_MDR;
        end
        ST_SW_WR: begin
          IorD     = 1'b1;
          MemWrite = wait_done_s;
        end
        ST_LUI: begin
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_PASS;
        end
        ST_J: begin
          PCWrite  = 1'b1;
          PCSource = PCS_JUMP;
        end
        ST_JAL: begin
          PCWrite  = 1'b1;
          PCSource = PCS_JUMP;
          RegWrite = 1'b1;
          RegDst   = DST_RA;
          MemtoReg = M2R_PC;
        end
        ST_JR: begin
          PCWrite = 1'b1;
          ALUSrcA = 1'b1;
          ALUOp   = ALU_PASS;
        end
        ST_BREAK: Break = 1'b1;
`ifdef UC_EXCEPTION_EN
        ST_EXC: begin
          EPCWrite = 1'b1;
          PCWrite  = 1'b1;
          PCSource = EXC_VEC_SEL;
        end
`endif
        default: Break = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_uc_multicycle_ctrl.sv
// Self-checking bench for uc_multicycle_ctrl: table rows, directed multi-cycle corner cases,
// and random instruction streams against an instruction-level expected-sequence model.
module tb_uc_multicycle_ctrl;

  localparam int MW = 2;
`ifdef UC_EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  typedef struct packed {
    logic pcw, pcwc, iord, memw, irw, regw, aw, bw, mdrw;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic srca;
    logic [1:0] srcb, regdst, m2r;
    logic bne, epcw, cause, brk;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         cycles;
    ctl_t       key;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [5:0] Op = 6'd0, Funct = 6'd0;
  logic Overflow = 1'b0;

  logic pcw_a, pcwc_a, iord_a, memw_a, irw_a, regw_a, aw_a, bw_a, mdrw_a, srca_a, bne_a, epcw_a, cause_a, brk_a;
  logic [1:0] pcsrc_a, srcb_a, regdst_a, m2r_a;
  logic [2:0] aluop_a;
  logic [4:0] st_a;
  logic pcw_b, pcwc_b, iord_b, memw_b, irw_b, regw_b, aw_b, bw_b, mdrw_b, srca_b, bne_b, epcw_b, cause_b, brk_b;
  logic [1:0] pcsrc_b, srcb_b, regdst_b, m2r_b;
  logic [2:0] aluop_b;
  logic [4:0] st_b;
  ctl_t oa, ob;

  assign oa = {pcw_a, pcwc_a, iord_a, memw_a, irw_a, regw_a, aw_a, bw_a, mdrw_a, pcsrc_a, aluop_a,
               srca_a, srcb_a, regdst_a, m2r_a, bne_a, epcw_a, cause_a, brk_a};
  assign ob = {pcw_b, pcwc_b, iord_b, memw_b, irw_b, regw_b, aw_b, bw_b, mdrw_b, pcsrc_b, aluop_b,
               srca_b, srcb_b, regdst_b, m2r_b, bne_b, epcw_b, cause_b, brk_b};

  uc_multicycle_ctrl #(.MEM_WAIT(MW), .EXC_VEC_SEL(2'b11)) dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Overflow(Overflow),
    .PCWrite(pcw_a), .PCWriteCond(pcwc_a), .IorD(iord_a), .MemWrite(memw_a), .IRWrite(irw_a),
    .RegWrite(regw_a), .AWrite(aw_a), .BWrite(bw_a), .MDRWrite(mdrw_a), .PCSource(pcsrc_a),
    .ALUOp(aluop_a), .ALUSrcA(srca_a), .ALUSrcB(srcb_a), .RegDst(regdst_a), .MemtoReg(m2r_a),
    .BranchNe(bne_a), .EPCWrite(epcw_a), .Cause(cause_a), .Break(brk_a), .State(st_a));

  uc_multicycle_ctrl #(.MEM_WAIT(0), .EXC_VEC_SEL(2'b11)) dut0 (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Overflow(Overflow),
    .PCWrite(pcw_b), .PCWriteCond(pcwc_b), .IorD(iord_b), .MemWrite(memw_b), .IRWrite(irw_b),
    .RegWrite(regw_b), .AWrite(aw_b), .BWrite(bw_b), .MDRWrite(mdrw_b), .PCSource(pcsrc_b),
    .ALUOp(aluop_b), .ALUSrcA(srca_b), .ALUSrcB(srcb_b), .RegDst(regdst_b), .MemtoReg(m2r_b),
    .BranchNe(bne_b), .EPCWrite(epcw_b), .Cause(cause_b), .Break(brk_b), .State(st_b));

  always #5 Clk = ~Clk;

  int   n_checks = 0;
  int   n_pass = 0;
  ctl_t exp_q[$];
  logic mcause = 1'b0;

  task automatic chk(input ctl_t act, input ctl_t exp, input string nm, input int cyc);
    n_checks++;
    if (act !== exp) $display("FAIL %s cyc %0d: got %h want %h", nm, cyc, act, exp);
    else n_pass++;
  endtask

  task automatic chk_int(input int act, input int exp, input string nm);
    n_checks++;
    if (act != exp) $display("FAIL %s: got %0d want %0d", nm, act, exp);
    else n_pass++;
  endtask

  function automatic void push(input ctl_t c);
    ctl_t w = c;
    w.cause = mcause;
    exp_q.push_back(w);
  endfunction

  function automatic void push_exc(input logic c);
    mcause = c;
    push(ctl_t'{epcw: 1'b1, pcw: 1'b1, pcsrc: 2'b11, default: '0});
  endfunction

  // Expected control words, cycle by cycle, for one instruction starting at fetch
  function automatic void gen_seq(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input int mw);
    bit trap = EXC_EN && ovf;
    exp_q = {};
    for (int i = 0; i <= mw; i++)
      push(ctl_t'{srcb: 2'b01, irw: (i == mw), pcw: (i == mw), default: '0});
    push(ctl_t'{aw: 1'b1, bw: 1'b1, srcb: 2'b11, default: '0});
    if (op == 6'h00 && fn == 6'h0D) begin
      push(ctl_t'{brk: 1'b1, default: '0});
    end else if (op == 6'h00 && fn == 6'h08) begin
      push(ctl_t'{pcw: 1'b1, srca: 1'b1, aluop: 3'b011, default: '0});
    end else begin
      case (op)
        6'h00: begin
          push(ctl_t'{srca: 1'b1, aluop: 3'b010, default: '0});
          push(ctl_t'{regw: !trap, regdst: 2'b01, default: '0});
          if (trap) push_exc(1'b1);
        end
        6'h08, 6'h0F: begin
          if (op == 6'h08) push(ctl_t'{srca: 1'b1, srcb: 2'b10, default: '0});
          else push(ctl_t'{srcb: 2'b10, aluop: 3'b011, default: '0});
          push(ctl_t'{regw: !trap, default: '0});
          if (trap) push_exc(1'b1);
        end
        6'h04, 6'h05: push(ctl_t'{srca: 1'b1, aluop: 3'b001, pcwc: 1'b1, pcsrc: 2'b01, bne: (op == 6'h05), default: '0});
        6'h23, 6'h2B: begin
          push(ctl_t'{srca: 1'b1, srcb: 2'b10, default: '0});
          for (int i = 0; i <= mw; i++)
            push(ctl_t'{iord: 1'b1, mdrw: (op == 6'h23 && i == mw), memw: (op == 6'h2B && i == mw), default: '0});
          if (op == 6'h23) push(ctl_t'{regw: 1'b1, m2r: 2'b01, default: '0});
        end
        6'h02: push(ctl_t'{pcw: 1'b1, pcsrc: 2'b10, default: '0});
        6'h03: push(ctl_t'{pcw: 1'b1, pcsrc: 2'b10, regw: 1'b1, regdst: 2'b10, m2r: 2'b10, default: '0});
        default: if (EXC_EN) push_exc(1'b0);
      endcase
    end
  endfunction

  // Entry/exit: just after a negedge with the DUT sitting at the start of FETCH
  task automatic run_seq(input bit which, input logic [5:0] op, input logic [5:0] fn, input logic ovf, input string nm);
    gen_seq(op, fn, ovf, which ? 0 : MW);
    Op = op; Funct = fn; Overflow = ovf;
    foreach (exp_q[i]) begin
      if (i > 0) @(negedge Clk);
      #1;
      chk(which ? ob : oa, exp_q[i], nm, i);
    end
    @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk(oa, ctl_t'(0), "rst_out_a", 0);
    chk(ob, ctl_t'(0), "rst_out_b", 0);
    chk_int(int'(st_a), 0, "rst_state_a");
    @(negedge Clk);
    Reset = 1'b0;
    mcause = 1'b0;
  endtask

  task automatic rand_instr(input bit which, input string nm);
    logic [5:0] ops[10] = '{6'h00, 6'h00, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B, 6'h0F, 6'h02, 6'h03};
    logic [5:0] bad[4]  = '{6'h01, 6'h06, 6'h1A, 6'h3F};
    int k = $urandom_range(0, 10);
    logic [5:0] op = (k == 10) ? bad[$urandom_range(0, 3)] : ops[k];
    logic [5:0] fn = 6'($urandom_range(0, 63));
    if (fn == 6'h0D) fn = 6'h20;
    if (op == 6'h00 && $urandom_range(0, 3) == 0) fn = 6'h08;
    run_seq(which, op, fn, 1'($urandom_range(0, 1)), nm);
  endtask

  vec_t tbl[11];

  initial begin
    int first, got;
    tbl[0]  = '{6'h00, 6'h20, 6, ctl_t'{srca: 1'b1, aluop: 3'b010, default: '0}};
    tbl[1]  = '{6'h08, 6'h00, 6, ctl_t'{srca: 1'b1, srcb: 2'b10, default: '0}};
    tbl[2]  = '{6'h04, 6'h00, 5, ctl_t'{srca: 1'b1, aluop: 3'b001, pcwc: 1'b1, pcsrc: 2'b01, default: '0}};
    tbl[3]  = '{6'h05, 6'h00, 5, ctl_t'{srca: 1'b1, aluop: 3'b001, pcwc: 1'b1, pcsrc: 2'b01, bne: 1'b1, default: '0}};
    tbl[4]  = '{6'h23, 6'h00, 9, ctl_t'{srca: 1'b1, srcb: 2'b10, default: '0}};
    tbl[5]  = '{6'h2B, 6'h00, 8, ctl_t'{srca: 1'b1, srcb: 2'b10, default: '0}};
    tbl[6]  = '{6'h0F, 6'h00, 6, ctl_t'{srcb: 2'b10, aluop: 3'b011, default: '0}};
    tbl[7]  = '{6'h02, 6'h00, 5, ctl_t'{pcw: 1'b1, pcsrc: 2'b10, default: '0}};
    tbl[8]  = '{6'h03, 6'h00, 5, ctl_t'{pcw: 1'b1, pcsrc: 2'b10, regw: 1'b1, regdst: 2'b10, m2r: 2'b10, default: '0}};
    tbl[9]  = '{6'h00, 6'h08, 5, ctl_t'{pcw: 1'b1, srca: 1'b1, aluop: 3'b011, default: '0}};
`ifdef UC_EXCEPTION_EN
    tbl[10] = '{6'h3F, 6'h00, 5, ctl_t'{epcw: 1'b1, pcw: 1'b1, pcsrc: 2'b11, default: '0}};
`else
    tbl[10] = '{6'h3F, 6'h00, 4, ctl_t'{srcb: 2'b01, default: '0}};
`endif

    // Table: the word right after DECODE, and the spacing between IRWrite pulses
    foreach (tbl[r]) begin
      do_reset();
      Op = tbl[r].op; Funct = tbl[r].fn; Overflow = 1'b0;
      first = -1; got = -1;
      for (int k = 0; k < 40; k++) begin
        #1;
        if (k == 4) chk(oa, tbl[r].key, $sformatf("tbl%0d_key", r), k);
        if (oa.irw) begin
          if (first < 0) first = k;
          else begin
            got = k - first;
            break;
          end
        end
        @(negedge Clk);
      end
      chk_int(got, tbl[r].cycles, $sformatf("tbl%0d_len", r));
    end

    // BREAK is sticky for 20 cycles, then a Reset pulse returns to FETCH
    do_reset();
    run_seq(1'b0, 6'h00, 6'h0D, 1'b0, "brk_entry");
    for (int k = 0; k < 20; k++) begin
      #1;
      chk(oa, ctl_t'{brk: 1'b1, default: '0}, "brk_hold", k);
      @(negedge Clk);
    end
    Reset = 1'b1;
    #1;
    chk(oa, ctl_t'(0), "brk_rst", 0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk(oa, ctl_t'{srcb: 2'b01, default: '0}, "brk_refetch", 0);

    // Reset in the middle of a load read: gated same cycle, clean refetch afterwards
    do_reset();
    Op = 6'h23; Funct = 6'h00;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        #1;
        chk(oa, ctl_t'{iord: 1'b1, default: '0}, "lw_mid_rd", k);
      end
      @(negedge Clk);
    end
    Reset = 1'b1;
    #1;
    chk(oa, ctl_t'(0), "lw_mid_rst", 0);
    @(negedge Clk);
    Reset = 1'b0;
    mcause = 1'b0;
    run_seq(1'b0, 6'h23, 6'h00, 1'b0, "lw_after_rst");
    run_seq(1'b0, 6'h08, 6'h00, 1'b1, "addi_ovf");
    run_seq(1'b0, 6'h00, 6'h20, 1'b0, "rtype");

    for (int n = 0; n < 50; n++) rand_instr(1'b0, "rand_mw2");

    // Zero wait states on the second instance
    do_reset();
    run_seq(1'b1, 6'h23, 6'h00, 1'b0, "lw_mw0");
    run_seq(1'b1, 6'h2B, 6'h00, 1'b0, "sw_mw0");
    for (int n = 0; n < 30; n++) rand_instr(1'b1, "rand_mw0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
